// File: rtl/up_down_mod_311_if.sv
// up_down_mod_311_if: control/status bundle for the up/down modulo counter
//   en/ud/clr/load/load_val/max/sat : commands driven by the master
//   count/tc/wrap/sat_hit           : counter state returned by the slave
interface up_down_mod_311_if #(parameter int WIDTH = 8);
    logic             en_311;
    logic             ud_311;
    logic             clr_311;
    logic             load_311;
    logic [WIDTH-1:0] load_val_311;
    logic [WIDTH-1:0] max_311;
    logic             sat_311;
    logic [WIDTH-1:0] count_311;
    logic             tc_311;
    logic             wrap_311;
    logic             sat_hit_311;
    modport master (
        output en_311, ud_311, clr_311, load_311, load_val_311, max_311, sat_311,
        input  count_311, tc_311, wrap_311, sat_hit_311
    );
    modport slave (
        input  en_311, ud_311, clr_311, load_311, load_val_311, max_311, sat_311,
        output count_311, tc_311, wrap_311, sat_hit_311
    );
endinterface

// File: rtl/up_down_mod_311.sv
// up_down_mod_311: parametrised up/down modulo counter with clear, load, wrap/saturate
//   clk_311   : clock, rising edge
//   reset_311 : asynchronous active-low reset
//   bus       : slave side of up_down_mod_311_if (commands in, count and flags out)
module up_down_mod_311 #(
    parameter int WIDTH = 8
) (
    input logic             clk_311,
    input logic             reset_311,
    up_down_mod_311_if.slave bus
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sat_hit_q, sat_hit_d;
    always_comb begin
        count_d   = count_q;
        wrap_d    = 1'b0;
        sat_hit_d = sat_hit_q;
        if (bus.clr_311) begin
            count_d   = bus.ud_311 ? '0 : bus.max_311;
            sat_hit_d = 1'b0;
        end else if (bus.load_311) begin
            count_d = (bus.load_val_311 > bus.max_311) ? bus.max_311 : bus.load_val_311;
        end else if (bus.en_311) begin
            if (bus.ud_311) begin
                if (count_q < bus.max_311) begin
                    count_d = count_q + 1'b1;
                end else if (bus.sat_311) begin
                    count_d   = bus.max_311;
                    sat_hit_d = 1'b1;
                end else begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                // a count left above a lowered max snaps back into range silently
                if (count_q > bus.max_311) begin
                    count_d = bus.max_311;
                end else if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else if (bus.sat_311) begin
                    sat_hit_d = 1'b1;
                end else begin
                    count_d = bus.max_311;
                    wrap_d  = 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk_311 or negedge reset_311) begin
        if (!reset_311) begin
            count_q   <= '0;
            wrap_q    <= 1'b0;
            sat_hit_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            sat_hit_q <= sat_hit_d;
        end
    end
    assign bus.count_311   = count_q;
    assign bus.wrap_311    = wrap_q;
    assign bus.sat_hit_311 = sat_hit_q;
    assign bus.tc_311      = bus.ud_311 ? (count_q >= bus.max_311) : (count_q == '0);
endmodule

// File: doc/up_down_mod_311.md
# up_down_mod_311

Parametrised up/down modulo counter. It supersedes the fixed 4-bit up/down counter with:
- configurable width;
- a run-time modulus;
- synchronous clear and parallel load;
- count enable;
- wrap or saturate mode;
- terminal-count and wrap-event flags.

It is the general-purpose counter primitive for the counters library: dividers, event counters and address sequencers instantiate it.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (2..32)

Ports:
- clk_311  input  1  clock; all state updates on rising edge
- reset_311  input  1  asynchronous, active-low reset
- en_311  input  1  count enable; a step occurs only when high
- ud_311  input  1  direction: 1 = up, 0 = down
- clr_311  input  1  synchronous clear (direction-dependent value, see Operation)
- load_311  input  1  synchronous parallel load
- load_val_311  input  WIDTH  value to load
- max_311  input  WIDTH  run-time upper bound; counting range is 0..max_311
- sat_311  input  1  mode: 0 = wrap, 1 = saturate
- count_311  output  WIDTH  registered count value
- tc_311  output  1  combinational terminal count
- wrap_311  output  1  registered one-cycle pulse on a wrap event
- sat_hit_311  output  1  registered sticky flag set on a saturation event

## Operation
- Async reset (reset_311 = 0):
  - count_311 = 0, wrap_311 = 0, sat_hit_311 = 0, immediately and independent of the clock.
- Synchronous priority per rising edge: clr_311 > load_311 > en_311 > hold.
- Clear:
  - count ← 0 if ud_311 = 1, else count ← max_311.
  - sat_hit_311 ← 0.
  - wrap_311 ← 0.
- Load:
  - count ← min(load_val_311, max_311).
  - wrap_311 ← 0.
  - sat_hit_311 unchanged.
- Enabled step, up (ud_311 = 1):
  - count < max_311: count + 1.
  - count ≥ max_311, wrap mode: count ← 0 and wrap_311 pulses.
  - count ≥ max_311, saturate mode: count ← max_311 and sat_hit_311 ← 1.
- Enabled step, down (ud_311 = 0):
  - count > max_311 (stale after max_311 was lowered): count ← max_311, no flag.
  - 0 < count ≤ max_311: count − 1.
  - count = 0, wrap mode: count ← max_311 and wrap_311 pulses.
  - count = 0, saturate mode: count stays 0 and sat_hit_311 ← 1.
- Hold (no clr, load or en): count unchanged, wrap_311 ← 0.
- tc_311 = (ud_311 & count_311 ≥ max_311) | (~ud_311 & count_311 = 0).
  - Purely combinational.
  - Asserted regardless of en_311.
- max_311 = 0: the range is the single value 0.
  - Wrap mode: every enabled step wraps to 0 and pulses wrap_311.
  - Saturate mode: every enabled step sets sat_hit_311.
- Arithmetic is WIDTH-bit unsigned. The counter never produces an intermediate value outside 0..max_311, except when a stale value is left from a max_311 change; that value is corrected on the next enabled step.
- Direction and mode may change on any cycle. Each edge uses the values sampled at that edge.

## Timing
- Latency of 1 clock for all synchronous operations. The new count is visible after the rising edge where the command was sampled.
- wrap_311 is high for exactly the one cycle following the wrapping edge, i.e. while count_311 shows the wrapped value.
  - Back-to-back wraps (e.g. max_311 = 0) keep it high continuously.
- sat_hit_311 rises on the edge that would have exceeded the range. It stays high until clr_311 or reset_311.
- Reset deassertion mid-operation: the first active edge after release behaves as from count 0.
- Simultaneous clr_311 and load_311: clear wins. Load and en together: load wins and no step occurs.

## Test plan
- Async reset then release with en = 1, ud = 1, max = 9, sat = 0, 12 clocks:
  - count_311 = 1..9, 0, 1, 2.
  - wrap_311 high in exactly the cycle count shows 0.
  - tc_311 high while count = 9.
- Down, wrap mode, max = 5, load 2, en for 4 clocks:
  - count_311 = 1, 0, 5, 4.
  - wrap_311 pulses once, with count = 5.
- Saturate mode, up, max = 3, from 0, 6 clocks:
  - count_311 = 1, 2, 3, 3, 3, 3.
  - sat_hit_311 rises on the 4th edge and stays high.
  - clr with ud = 1 gives count = 0, sat_hit_311 = 0.
- Priority and clamp:
  - clr + load + en with ud = 0, max = 7: count = 7.
  - load_val = 200 with max = 50: count = 50.
  - load + en: no step.
- Stale value: count = 40, then max lowered to 10:
  - down step gives count = 10.
  - up step in wrap mode gives count = 0 with wrap_311 pulse.
- reset_311 asserted asynchronously mid-count (between edges) at count = 6:
  - count_311 and both flags go to 0 immediately, with no clock.
  - Counting resumes from 0 after release.
